// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file definitions used by decode, issue and writeback.
// Pure types and constants; no logic.
package regfile_mp_sb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int AW_DEF = addr_width(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Register-file port bundle: write ports, read ports, busy lookup and scoreboard set.
// Master is the core side (issue/writeback), slave is the register file.
interface regfile_mp_sb_if #(
    parameter int XLEN = regfile_mp_sb_pkg::XLEN_DEF,
    parameter int NREG = regfile_mp_sb_pkg::NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = regfile_mp_sb_pkg::addr_width(NREG);

    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, sb_set, sb_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: set at issue, cleared by any writeback, set wins over clear.
// rd_busy is combinational from current state (latency 0); no backpressure.
module regfile_mp_sb_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    localparam int AW     = addr_width(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    fwd_hit,
    output logic [NRD-1:0]    rd_busy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                clr_vec[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
        if (sb_set && !(ZERO_R0 != 0 && sb_addr == AW'(REG_ZERO))) begin
            set_vec[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    assign busy_vec = busy_q;

    // A forwarded read already has its value, so its producer is no longer outstanding.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_q[rd_addr[i*AW +: AW]] & ~fwd_hit[i];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file in flops with write-to-read bypass and busy scoreboard.
// Reads are combinational (latency 0), writes land on the rising edge; no backpressure.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    regfile_mp_sb_if.slave rf
);

    localparam int AW = addr_width(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NRD-1:0]  fwd_hit;

    // Later ports overwrite earlier ones in the loop, so the highest index wins a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (rf.wr_en[p] && !(ZERO_R0 != 0 && rf.wr_addr[p*AW +: AW] == AW'(REG_ZERO))) begin
                    regs_q[rf.wr_addr[p*AW +: AW]] <= rf.wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] val;
        logic            hit;

        assign idx = rf.rd_addr[i*AW +: AW];

        always_comb begin
            val = regs_q[idx];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (rf.wr_en[p] && rf.wr_addr[p*AW +: AW] == idx) begin
                        val = rf.wr_data[p*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
            end
            if (ZERO_R0 != 0 && idx == AW'(REG_ZERO)) begin
                val = '0;
                hit = 1'b0;
            end
        end

        assign rf.rd_data[i*XLEN +: XLEN] = val;
        assign fwd_hit[i]                 = hit;
    end

    regfile_mp_sb_scoreboard #(
        .NREG    (NREG),
        .NRD     (NRD),
        .NWR     (NWR),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (rf.wr_en),
        .wr_addr  (rf.wr_addr),
        .sb_set   (rf.sb_set),
        .sb_addr  (rf.sb_addr),
        .rd_addr  (rf.rd_addr),
        .fwd_hit  (fwd_hit),
        .rd_busy  (rf.rd_busy),
        .busy_vec (rf.busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed vector table, reset and no-bypass sequences, random regression.
module tb_regfile_mp_sb;
    import regfile_mp_sb_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;
    localparam int NTBL = 21;

    typedef struct packed {
        logic [NRD*XLEN-1:0] d;
        logic [NRD-1:0]      b;
        logic [NREG-1:0]     bv;
    } exp_t;

    typedef struct packed {
        logic [1:0]  we;
        reg_idx_t    wa0;
        logic [31:0] wd0;
        reg_idx_t    wa1;
        logic [31:0] wd1;
        reg_idx_t    ra;
        logic        sb;
        reg_idx_t    sa;
        logic [31:0] erd;
        logic        ebusy;
        logic [31:0] ebv;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) rf ();
    regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(1),   .NWR(NWR)) nb ();

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_R0(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .rf(rf)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(1), .NWR(NWR), .BYPASS(0), .ZERO_R0(1)) u_nb (
        .clk(clk), .reset_n(reset_n), .rf(nb)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] m_regs [NREG];
    logic [31:0] m_busy;
    vec_t        tbl [NTBL];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] we, input reg_idx_t wa0, input logic [31:0] wd0,
                         input reg_idx_t wa1, input logic [31:0] wd1,
                         input reg_idx_t ra0, input reg_idx_t ra1, input reg_idx_t ra2,
                         input logic sb, input reg_idx_t sa);
        rf.wr_en   = we;
        rf.wr_addr = {wa1, wa0};
        rf.wr_data = {wd1, wd0};
        rf.rd_addr = {ra2, ra1, ra0};
        rf.sb_set  = sb;
        rf.sb_addr = sa;
    endtask

    task automatic drive_idle(input reg_idx_t ra);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, ra, ra, ra, 1'b0, 5'd0);
    endtask

    // Reference model: predicted outputs from model state and the inputs currently driven.
    function automatic exp_t predict();
        exp_t        e;
        reg_idx_t    a;
        logic [31:0] v;
        logic        f;
        e.d  = '0;
        e.b  = '0;
        e.bv = m_busy;
        for (int i = 0; i < NRD; i++) begin
            a = rf.rd_addr[i*AW +: AW];
            v = m_regs[a];
            f = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (rf.wr_en[p] && rf.wr_addr[p*AW +: AW] == a) begin
                    v = rf.wr_data[p*XLEN +: XLEN];
                    f = 1'b1;
                end
            end
            if (a == 5'd0) begin
                v = 32'd0;
                f = 1'b0;
            end
            e.d[i*XLEN +: XLEN] = v;
            e.b[i] = m_busy[a] & ~f;
        end
        return e;
    endfunction

    task automatic model_clock();
        logic [31:0] nbusy;
        reg_idx_t    a;
        nbusy = m_busy;
        for (int p = 0; p < NWR; p++) begin
            a = rf.wr_addr[p*AW +: AW];
            if (rf.wr_en[p]) begin
                nbusy[a] = 1'b0;
                if (a != 5'd0) m_regs[a] = rf.wr_data[p*XLEN +: XLEN];
            end
        end
        if (rf.sb_set && rf.sb_addr != 5'd0) nbusy[rf.sb_addr] = 1'b1;
        m_busy = nbusy;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) m_regs[r] = 32'd0;
        m_busy = 32'd0;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            cmp({tag, " queue"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < NRD; i++) begin
            cmp($sformatf("%s rd_data[%0d]", tag, i), 64'(rf.rd_data[i*XLEN +: XLEN]), 64'(e.d[i*XLEN +: XLEN]));
        end
        cmp({tag, " rd_busy"}, 64'(rf.rd_busy), 64'(e.b));
        cmp({tag, " busy_vec"}, 64'(rf.busy_vec), 64'(e.bv));
    endtask

    function automatic vec_t mk(input logic [1:0] we, input reg_idx_t wa0, input logic [31:0] wd0,
                                input reg_idx_t wa1, input logic [31:0] wd1, input reg_idx_t ra,
                                input logic sb, input reg_idx_t sa, input logic [31:0] erd,
                                input logic ebusy, input logic [31:0] ebv);
        vec_t v;
        v = '{we, wa0, wd0, wa1, wd1, ra, sb, sa, erd, ebusy, ebv};
        return v;
    endfunction

    function automatic reg_idx_t rnd_idx();
        if ($urandom_range(0, 1) == 0) return reg_idx_t'($urandom_range(0, 7));
        return reg_idx_t'($urandom_range(0, 31));
    endfunction

    task automatic nb_cycle(input logic [1:0] we, input logic [31:0] wd0, input logic [31:0] wd1,
                            input logic sb, input logic [31:0] erd, input logic ebusy,
                            input logic [31:0] ebv, input string tag);
        @(negedge clk);
        nb.wr_en   = we;
        nb.wr_addr = {5'd9, 5'd9};
        nb.wr_data = {wd1, wd0};
        nb.rd_addr = 5'd9;
        nb.sb_set  = sb;
        nb.sb_addr = 5'd9;
        #1;
        cmp({tag, " rd_data"}, 64'(nb.rd_data), 64'(erd));
        cmp({tag, " rd_busy"}, 64'(nb.rd_busy), 64'(ebusy));
        cmp({tag, " busy_vec"}, 64'(nb.busy_vec), 64'(ebv));
    endtask

    initial begin
        vec_t v;
        exp_t e;

        tbl[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0,      5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd0);
        tbl[1]  = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd0);
        tbl[2]  = mk(2'b01, 5'd0, 32'h1234,     5'd0, 32'd0,      5'd0, 1'b0, 5'd0, 32'd0,        1'b0, 32'd0);
        tbl[3]  = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd0, 1'b0, 5'd0, 32'd0,        1'b0, 32'd0);
        tbl[4]  = mk(2'b11, 5'd7, 32'hAAAA,     5'd7, 32'h5555,   5'd7, 1'b0, 5'd0, 32'h5555,     1'b0, 32'd0);
        tbl[5]  = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd7, 1'b0, 5'd0, 32'h5555,     1'b0, 32'd0);
        tbl[6]  = mk(2'b01, 5'd9, 32'd1,        5'd0, 32'd0,      5'd9, 1'b0, 5'd0, 32'd1,        1'b0, 32'd0);
        tbl[7]  = mk(2'b10, 5'd0, 32'd0,        5'd9, 32'd2,      5'd9, 1'b0, 5'd0, 32'd2,        1'b0, 32'd0);
        tbl[8]  = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd9, 1'b0, 5'd0, 32'd2,        1'b0, 32'd0);
        tbl[9]  = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd3, 1'b1, 5'd3, 32'd0,        1'b0, 32'd0);
        tbl[10] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd3, 1'b0, 5'd0, 32'd0,        1'b1, 32'h8);
        tbl[11] = mk(2'b01, 5'd3, 32'h33,       5'd0, 32'd0,      5'd3, 1'b1, 5'd3, 32'h33,       1'b0, 32'h8);
        tbl[12] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd3, 1'b0, 5'd0, 32'h33,       1'b1, 32'h8);
        tbl[13] = mk(2'b10, 5'd0, 32'd0,        5'd3, 32'h44,     5'd3, 1'b0, 5'd0, 32'h44,       1'b0, 32'h8);
        tbl[14] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd3, 1'b0, 5'd0, 32'h44,       1'b0, 32'd0);
        tbl[15] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd0, 1'b1, 5'd0, 32'd0,        1'b0, 32'd0);
        tbl[16] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd0, 1'b0, 5'd0, 32'd0,        1'b0, 32'd0);
        tbl[17] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd9, 1'b1, 5'd9, 32'd2,        1'b0, 32'd0);
        tbl[18] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd9, 1'b1, 5'd9, 32'd2,        1'b1, 32'h200);
        tbl[19] = mk(2'b01, 5'd9, 32'd3,        5'd0, 32'd0,      5'd9, 1'b0, 5'd0, 32'd3,        1'b0, 32'h200);
        tbl[20] = mk(2'b00, 5'd0, 32'd0,        5'd0, 32'd0,      5'd9, 1'b0, 5'd0, 32'd3,        1'b0, 32'd0);

        nb.wr_en = '0; nb.wr_addr = '0; nb.wr_data = '0; nb.rd_addr = '0; nb.sb_set = 1'b0; nb.sb_addr = '0;
        drive_idle(5'd5);
        model_reset();

        // Reset state before any clock.
        #3;
        exp_q.push_back('{d: '0, b: '0, bv: '0});
        check_out("reset_state");
        #9 reset_n = 1'b1;

        // Fill x1..x31 with idx*0x11 while marking some registers busy.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            drive((k < 15) ? 2'b11 : 2'b01, reg_idx_t'(2*k+1), 32'((2*k+1) * 32'h11),
                  reg_idx_t'((k < 15) ? 2*k+2 : 0), 32'((2*k+2) * 32'h11),
                  reg_idx_t'(2*k), reg_idx_t'(2*k+1), 5'd0, 1'b1, reg_idx_t'(31-k));
            exp_q.push_back(predict());
            #1 check_out("fill");
            model_clock();
        end

        // Mid-cycle async reset: outputs clear without a clock edge.
        @(negedge clk);
        drive_idle(5'd0);
        rf.rd_addr = {5'd31, 5'd17, 5'd5};
        exp_q.push_back(predict());
        #1 check_out("pre_reset");
        #1 reset_n = 1'b0;
        #1;
        exp_q.push_back('{d: '0, b: '0, bv: '0});
        check_out("async_reset");
        drive(2'b01, 5'd5, 32'h77, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 1'b1, 5'd5);
        #1;
        exp_q.push_back('{d: {3{32'h77}}, b: '0, bv: '0});
        check_out("reset_bypass");
        model_reset();
        @(negedge clk);
        drive_idle(5'd0);
        #2 reset_n = 1'b1;

        for (int t = 0; t < NTBL; t++) begin
            @(negedge clk);
            v = tbl[t];
            drive(v.we, v.wa0, v.wd0, v.wa1, v.wd1, v.ra, v.ra, v.ra, v.sb, v.sa);
            e.d  = {3{v.erd}};
            e.b  = {3{v.ebusy}};
            e.bv = v.ebv;
            exp_q.push_back(e);
            #1 check_out($sformatf("tbl%0d", t));
            model_clock();
        end

        // Same write/read sequence on the no-bypass instance: reads see the old value.
        @(negedge clk);
        drive_idle(5'd0);
        nb_cycle(2'b01, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0,     "nb_wr1");
        nb_cycle(2'b10, 32'd0, 32'd2, 1'b0, 32'd1, 1'b1, 32'h200,   "nb_wr2");
        nb_cycle(2'b00, 32'd0, 32'd0, 1'b0, 32'd2, 1'b0, 32'd0,     "nb_rd");

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            drive(2'($urandom_range(0, 3)), rnd_idx(), $urandom, rnd_idx(), $urandom,
                  rnd_idx(), rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx());
            exp_q.push_back(predict());
            #1 check_out("rand");
            if (reset_n) begin
                model_clock();
            end else begin
                @(negedge clk);
                drive_idle(5'd0);
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
